mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_resp_reg.sv | 47 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Imported by the interface, the arbiter and its response register.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W = 4;

  typedef enum logic {
    PRI_DATA  = 1'b0,
    PRI_FETCH = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and single-port memory bus of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_resp_reg.sv
// Captures memory read data in the grant cycle and returns it,
// one cycle later, to whichever port was granted.
module mem_resp_reg
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_gnt_i,
  input  logic              dm_gnt_i,
  input  logic              dm_we_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o
);

  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_gnt_i;
      dm_rvalid_q <= dm_gnt_i;
      if (if_gnt_i)
        if_rdata_q <= mem_rdata_i;
      if (dm_gnt_i)
        dm_rdata_q <= dm_we_i ? '0 : mem_rdata_i;
    end
  end

  // Mask in-flight responses while reset is asserted.
  assign if_rvalid_o = if_rvalid_q & ~rst_i;
  assign dm_rvalid_o = dm_rvalid_q & ~rst_i;
  assign if_rdata_o  = rst_i ? '0 : if_rdata_q;
  assign dm_rdata_o  = rst_i ? '0 : dm_rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, data-first
// with a starvation counter that forces a fetch grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_gnt;
  logic              dm_gnt;

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PRI_DATA: begin
          dm_gnt = bus.dm_req;
          if_gnt = bus.if_req & ~bus.dm_req;
        end
        PRI_FETCH: begin
          if_gnt = bus.if_req;
          dm_gnt = bus.dm_req & ~bus.if_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dm_gnt && bus.if_req)
      cnt_d = cnt_q + 1'b1;
    else if (if_gnt || !bus.if_req)
      cnt_d = '0;
    state_d = state_q;
    // Switch on the same edge the count hits the limit.
    unique case (1'b1)
      (state_q == PRI_DATA):
        if (cnt_d == CNT_W'(STARVE_LIMIT))
          state_d = PRI_FETCH;
      (state_q == PRI_FETCH):
        if (if_gnt)
          state_d = PRI_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRI_DATA;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (if_gnt)
        addr_q <= bus.if_addr;
      else if (dm_gnt)
        addr_q <= bus.dm_addr;
      if (dm_gnt)
        wdata_q <= bus.dm_wdata;
    end
  end

  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;
  assign bus.mem_we = dm_gnt & bus.dm_we;

  assign bus.mem_addr =
    rst    ? '0 :
    if_gnt ? bus.if_addr :
    dm_gnt ? bus.dm_addr : addr_q;

  assign bus.mem_wdata =
    rst    ? '0 :
    dm_gnt ? bus.dm_wdata : wdata_q;

  mem_resp_reg #(
    .DATA_W(DATA_W)
  ) u_resp (
    .clk_i      (clk),
    .rst_i      (rst),
    .if_gnt_i   (if_gnt),
    .dm_gnt_i   (dm_gnt),
    .dm_we_i    (bus.dm_we),
    .mem_rdata_i(bus.mem_rdata),
    .if_rvalid_o(bus.if_rvalid),
    .if_rdata_o (bus.if_rdata),
    .dm_rvalid_o(bus.dm_rvalid),
    .dm_rdata_o (bus.dm_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a
// cycle-level reference of the arbitration and response rules.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      default:  return DW'((a * 40503) ^ 16'h5A5A);
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT
  logic [DW-1:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin : mem_proc
    for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Reference model state
  logic [DW-1:0] mm [0:65535];
  logic          e_ifg, e_dmg, wants_f;
  logic [AW-1:0] e_addr, addr_hold;
  logic          pend_if, pend_dm;
  logic [DW-1:0] pend_if_d, pend_dm_d;
  logic [DW-1:0] exp_if_rd, exp_dm_rd;
  int            passes;
  logic          forced;

  initial begin : cmp
    for (int i = 0; i < 65536; i++) mm[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_dm_gnt", bus.dm_gnt, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_dm_rvalid", bus.dm_rvalid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        pend_if = 0;
        pend_dm = 0;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        addr_hold = '0;
        passes = 0;
        forced = 0;
      end else begin
        // Starved fetch wins; otherwise data first.
        wants_f = forced ? bus.if_req
                         : (bus.if_req && !bus.dm_req);
        e_ifg = wants_f;
        e_dmg = bus.dm_req && !wants_f;
        e_addr = e_ifg ? bus.if_addr :
                 e_dmg ? bus.dm_addr : addr_hold;
        chk("if_gnt", bus.if_gnt, e_ifg);
        chk("dm_gnt", bus.dm_gnt, e_dmg);
        chk("one_gnt", bus.if_gnt & bus.dm_gnt, 0);
        chk("mem_we", bus.mem_we, e_dmg && bus.dm_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        if (e_dmg && bus.dm_we)
          chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);
        if (pend_if) exp_if_rd = pend_if_d;
        if (pend_dm) exp_dm_rd = pend_dm_d;
        chk("if_rvalid", bus.if_rvalid, pend_if);
        chk("dm_rvalid", bus.dm_rvalid, pend_dm);
        chk("if_rdata", bus.if_rdata, exp_if_rd);
        chk("dm_rdata", bus.dm_rdata, exp_dm_rd);
        pend_if = e_ifg;
        pend_dm = e_dmg;
        if (e_ifg) pend_if_d = mm[bus.if_addr];
        if (e_dmg) begin
          pend_dm_d = bus.dm_we ? '0 : mm[bus.dm_addr];
          if (bus.dm_we) mm[bus.dm_addr] = bus.dm_wdata;
        end
        addr_hold = e_addr;
        if (e_ifg) forced = 0;
        if (e_dmg && bus.if_req) passes++;
        else if (e_ifg || !bus.if_req) passes = 0;
        if (passes >= LIMIT) forced = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 16'hFFFF;
    return AW'($urandom_range(0, 31));
  endfunction

  logic [9:0] cont_pat;
  logic [7:0] drop_ifr;
  logic [7:0] drop_pat;
  logic       g_if, g_dm;

  initial begin : stim
    rst = 1'b1;
    bus.if_req = 0;
    bus.if_addr = '0;
    bus.dm_req = 0;
    bus.dm_we = 0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    cont_pat = 10'b1000010000;
    drop_ifr = 8'b1111_1011;
    drop_pat = 8'b1000_0000;
    tick();
    tick();
    @(negedge clk);
    chk("lit_rst_addr", bus.mem_addr, 0);
    tick();
    rst = 1'b0;

    // Single fetch
    bus.if_req = 1;
    bus.if_addr = 16'h0010;
    @(negedge clk);
    chk("lit_f_gnt", bus.if_gnt, 1);
    chk("lit_f_addr", bus.mem_addr, 16'h0010);
    tick();
    bus.if_req = 0;
    @(negedge clk);
    chk("lit_f_rvalid", bus.if_rvalid, 1);
    chk("lit_f_rdata", bus.if_rdata, 16'hBEEF);

    // Store then load
    tick();
    bus.dm_req = 1;
    bus.dm_we = 1;
    bus.dm_addr = 16'h0020;
    bus.dm_wdata = 16'h1234;
    @(negedge clk);
    chk("lit_st_gnt", bus.dm_gnt, 1);
    chk("lit_st_we", bus.mem_we, 1);
    chk("lit_st_wdata", bus.mem_wdata, 16'h1234);
    tick();
    bus.dm_we = 0;
    @(negedge clk);
    chk("lit_ld_we", bus.mem_we, 0);
    chk("lit_st_rvalid", bus.dm_rvalid, 1);
    chk("lit_st_rdata", bus.dm_rdata, 0);
    tick();
    bus.dm_req = 0;
    @(negedge clk);
    chk("lit_ld_rvalid", bus.dm_rvalid, 1);
    chk("lit_ld_rdata", bus.dm_rdata, 16'h1234);

    // Contention: D,D,D,D,F repeating
    tick();
    bus.if_req = 1;
    bus.if_addr = 16'h0010;
    bus.dm_req = 1;
    bus.dm_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk($sformatf("lit_cont%0d_if", i),
          bus.if_gnt, cont_pat[i]);
      chk($sformatf("lit_cont%0d_dm", i),
          bus.dm_gnt, !cont_pat[i]);
    end

    // Fetch drops after two data grants
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.if_req = drop_ifr[i];
      @(negedge clk);
      chk($sformatf("lit_drop%0d_if", i),
          bus.if_gnt, drop_pat[i]);
      chk($sformatf("lit_drop%0d_dm", i),
          bus.dm_gnt, !drop_pat[i]);
    end
    tick();
    bus.if_req = 0;
    bus.dm_req = 0;

    // Reset in the cycle after a load grant
    tick();
    bus.dm_req = 1;
    bus.dm_we = 0;
    bus.dm_addr = 16'h0020;
    @(negedge clk);
    chk("lit_pre_rst_gnt", bus.dm_gnt, 1);
    tick();
    rst = 1;
    bus.dm_req = 0;
    @(negedge clk);
    chk("lit_rst_dm_rvalid", bus.dm_rvalid, 0);
    chk("lit_rst_dm_rdata", bus.dm_rdata, 0);
    tick();
    rst = 0;
    bus.if_req = 1;
    bus.if_addr = 16'h0010;
    @(negedge clk);
    chk("lit_post_rst_gnt", bus.if_gnt, 1);
    tick();
    bus.if_req = 0;
    @(negedge clk);
    chk("lit_post_rst_dm_rv", bus.dm_rvalid, 0);
    chk("lit_post_rst_rdata", bus.if_rdata, 16'hBEEF);

    // Back-to-back fetches
    tick();
    bus.if_req = 1;
    bus.if_addr = 16'h0000;
    @(negedge clk);
    chk("lit_b2b_gnt", bus.if_gnt, 1);
    tick();
    bus.if_addr = 16'h0002;
    @(negedge clk);
    chk("lit_b2b0_rv", bus.if_rvalid, 1);
    chk("lit_b2b0_rd", bus.if_rdata, 16'h1111);
    tick();
    bus.if_addr = 16'h0004;
    @(negedge clk);
    chk("lit_b2b1_rv", bus.if_rvalid, 1);
    chk("lit_b2b1_rd", bus.if_rdata, 16'h2222);
    tick();
    bus.if_req = 0;
    @(negedge clk);
    chk("lit_b2b2_rv", bus.if_rvalid, 1);
    chk("lit_b2b2_rd", bus.if_rdata, 16'h3333);

    // Randomized traffic; requests held until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_if = bus.if_gnt;
      g_dm = bus.dm_gnt;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (!bus.if_req || g_if) begin
        bus.if_req = ($urandom_range(0, 3) != 0);
        bus.if_addr = rand_addr();
      end
      if (!bus.dm_req || g_dm) begin
        bus.dm_req = ($urandom_range(0, 3) != 0);
        bus.dm_we = $urandom_range(0, 1) == 1;
        bus.dm_addr = rand_addr();
        bus.dm_wdata = DW'($urandom);
      end
    end
    tick();
    rst = 0;
    bus.if_req = 0;
    bus.dm_req = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
